// File: rtl/audio_addr_gen.sv
// Flash-to-audio sample sequencer: fetches packed words over an Avalon-style read port and
// emits one SAMPLE_W slice per sample_tick, forward or reverse, with loop/stop and restart.
module audio_addr_gen #(
    parameter int unsigned       ADDR_W     = 23,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       SAMPLE_W   = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF,
    parameter bit                LOOP       = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                forward,
    input  logic                restart,
    output logic                flash_read,
    output logic [ADDR_W-1:0]   flash_addr,
    input  logic                flash_waitrequest,
    input  logic                flash_readdatavalid,
    input  logic [DATA_W-1:0]   flash_readdata,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                at_end,
    output logic                underrun
);

    localparam int unsigned      SPW      = DATA_W / SAMPLE_W;
    localparam int unsigned      IDX_W    = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitData, StReady} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                stopped_q, stopped_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic                flash_read_q, flash_read_d;
    logic [ADDR_W-1:0]   flash_addr_q, flash_addr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                at_end_q, at_end_d;
    logic                underrun_q, underrun_d;

    logic [ADDR_W-1:0]   restart_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic                at_bound;
    logic                exhausted;
    logic                run_tick;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stopped_d    = stopped_q;
        pend_d       = pend_q;
        word_d       = word_q;
        idx_d        = idx_q;
        dir_d        = dir_q;
        flash_read_d = flash_read_q;
        flash_addr_d = flash_addr_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        at_end_d     = 1'b0;
        underrun_d   = 1'b0;

        run_tick     = sample_tick && play;
        restart_addr = forward ? START_ADDR : END_ADDR;
        exhausted    = dir_q ? (idx_q == IDX_LAST) : (idx_q == '0);
        at_bound     = dir_q ? (addr_q == END_ADDR) : (addr_q == START_ADDR);
        if (dir_q) begin
            next_addr = at_bound ? START_ADDR : addr_q + 1'b1;
        end else begin
            next_addr = at_bound ? END_ADDR : addr_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                underrun_d = run_tick && !stopped_q;
                if (restart) begin
                    addr_d    = restart_addr;
                    stopped_d = 1'b0;
                end else if (play && !stopped_q) begin
                    state_d      = StReq;
                    flash_read_d = 1'b1;
                    flash_addr_d = addr_q;
                end
            end
            StReq: begin
                underrun_d = run_tick;
                if (restart) pend_d = 1'b1;
                if (!flash_waitrequest) begin
                    flash_read_d = 1'b0;
                    state_d      = StWaitData;
                end
            end
            StWaitData: begin
                underrun_d = run_tick;
                if (restart) pend_d = 1'b1;
                if (flash_readdatavalid) begin
                    // A restart seen during the transaction drops the returned word.
                    if (pend_q || restart) begin
                        pend_d    = 1'b0;
                        addr_d    = restart_addr;
                        stopped_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        word_d  = flash_readdata;
                        dir_d   = forward;
                        idx_d   = forward ? '0 : IDX_LAST;
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                if (restart) begin
                    addr_d    = restart_addr;
                    stopped_d = 1'b0;
                    state_d   = StIdle;
                end else if (run_tick) begin
                    sample_d = word_q[int'(idx_q) * SAMPLE_W +: SAMPLE_W];
                    valid_d  = 1'b1;
                    if (!exhausted) begin
                        idx_d = dir_q ? idx_q + 1'b1 : idx_q - 1'b1;
                    end else if (at_bound && !LOOP) begin
                        at_end_d  = 1'b1;
                        stopped_d = 1'b1;
                        addr_d    = dir_q ? START_ADDR : END_ADDR;
                        state_d   = StIdle;
                    end else begin
                        addr_d       = next_addr;
                        state_d      = StReq;
                        flash_read_d = 1'b1;
                        flash_addr_d = next_addr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= START_ADDR;
            stopped_q    <= 1'b0;
            pend_q       <= 1'b0;
            word_q       <= '0;
            idx_q        <= '0;
            dir_q        <= 1'b1;
            flash_read_q <= 1'b0;
            flash_addr_q <= START_ADDR;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            at_end_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stopped_q    <= stopped_d;
            pend_q       <= pend_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            dir_q        <= dir_d;
            flash_read_q <= flash_read_d;
            flash_addr_q <= flash_addr_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            at_end_q     <= at_end_d;
            underrun_q   <= underrun_d;
        end
    end

    assign flash_read   = flash_read_q;
    assign flash_addr   = flash_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign at_end       = at_end_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_addr_gen.sv
// Bench for audio_addr_gen: a looping 4-word instance and a stop-at-end 2-word instance,
// each served by a small flash model with controllable waitrequest.
module tb_audio_addr_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_tick;
    logic        play;
    logic        forward;
    logic        restart;
    logic        f_read   [2];
    logic [22:0] f_addr   [2];
    logic        wr       [2];
    logic        rdv      [2];
    logic [31:0] rdata    [2];
    logic [15:0] s_out    [2];
    logic        s_valid  [2];
    logic        at_end   [2];
    logic        underrun [2];

    always #5 clk = ~clk;

    audio_addr_gen #(.END_ADDR(23'd3), .LOOP(1'b1)) u_loop (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sample_tick         (sample_tick),
        .play                (play),
        .forward             (forward),
        .restart             (restart),
        .flash_read          (f_read[0]),
        .flash_addr          (f_addr[0]),
        .flash_waitrequest   (wr[0]),
        .flash_readdatavalid (rdv[0]),
        .flash_readdata      (rdata[0]),
        .sample_out          (s_out[0]),
        .sample_valid        (s_valid[0]),
        .at_end              (at_end[0]),
        .underrun            (underrun[0])
    );

    audio_addr_gen #(.END_ADDR(23'd1), .LOOP(1'b0)) u_stop (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sample_tick         (sample_tick),
        .play                (play),
        .forward             (forward),
        .restart             (restart),
        .flash_read          (f_read[1]),
        .flash_addr          (f_addr[1]),
        .flash_waitrequest   (wr[1]),
        .flash_readdatavalid (rdv[1]),
        .flash_readdata      (rdata[1]),
        .sample_out          (s_out[1]),
        .sample_valid        (s_valid[1]),
        .at_end              (at_end[1]),
        .underrun            (underrun[1])
    );

    function automatic logic [31:0] word(input logic [22:0] n);
        return 32'h0001_0000 + 32'h0002_0002 * {9'd0, n};
    endfunction

    // Flash model: data returns two edges after the accepting edge; also pulse counters.
    int          cnt       [2];
    logic [22:0] paddr     [2];
    int          valid_cnt [2] = '{0, 0};
    int          under_cnt [2] = '{0, 0};
    int          end_cnt   [2] = '{0, 0};
    int          read_cyc  [2] = '{0, 0};
    logic [22:0] acc0 [$];
    logic [22:0] acc1 [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= 0;
                rdv[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                rdv[k] <= 1'b0;
                if (cnt[k] == 2) begin
                    cnt[k] <= 1;
                end else if (cnt[k] == 1) begin
                    cnt[k]   <= 0;
                    rdv[k]   <= 1'b1;
                    rdata[k] <= word(paddr[k]);
                end
                if (f_read[k] && !wr[k]) begin
                    cnt[k]   <= 2;
                    paddr[k] <= f_addr[k];
                    if (k == 0) acc0.push_back(f_addr[k]);
                    else        acc1.push_back(f_addr[k]);
                end
                if (s_valid[k])  valid_cnt[k] <= valid_cnt[k] + 1;
                if (underrun[k]) under_cnt[k] <= under_cnt[k] + 1;
                if (at_end[k])   end_cnt[k]   <= end_cnt[k] + 1;
                if (f_read[k])   read_cyc[k]  <= read_cyc[k] + 1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] acc_at(input int k, input int idx);
        if (k == 0) return (idx >= 0 && idx < acc0.size()) ? acc0[idx] : 23'h7FFFFF;
        return (idx >= 0 && idx < acc1.size()) ? acc1[idx] : 23'h7FFFFF;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int gap);
        cycles(gap);
        sample_tick = 1'b1;
        cycles(1);
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        restart     = 1'b0;
        cycles(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_read(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (f_read[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_read", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        bit          fwd;
        logic [15:0] samp;
    } vec_t;

    vec_t        vecs [20];
    logic [22:0] exp_addr [10];
    int          base;
    int          v0;
    int          u0;
    int          n0;

    initial begin
        vecs = '{
            '{1'b1, 16'h0000}, '{1'b1, 16'h0001}, '{1'b1, 16'h0002}, '{1'b1, 16'h0003},
            '{1'b1, 16'h0004}, '{1'b1, 16'h0005}, '{1'b1, 16'h0006}, '{1'b1, 16'h0007},
            '{1'b1, 16'h0000}, '{1'b1, 16'h0001},
            '{1'b0, 16'h0007}, '{1'b0, 16'h0006}, '{1'b0, 16'h0005}, '{1'b0, 16'h0004},
            '{1'b0, 16'h0003}, '{1'b0, 16'h0002}, '{1'b0, 16'h0001}, '{1'b0, 16'h0000},
            '{1'b0, 16'h0007}, '{1'b0, 16'h0006}
        };
        exp_addr = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0, 23'd3, 23'd2, 23'd1, 23'd0, 23'd3};

        reset_n = 1'b0; sample_tick = 1'b0; play = 1'b0; forward = 1'b1; restart = 1'b0;
        wr[0] = 1'b0; wr[1] = 1'b0;
        cycles(2);
        check("rst_read",     {31'd0, f_read[0]},   32'd0);
        check("rst_addr",     {9'd0, f_addr[0]},    32'd0);
        check("rst_sample",   {16'd0, s_out[0]},    32'd0);
        check("rst_valid",    {31'd0, s_valid[0]},  32'd0);
        check("rst_at_end",   {31'd0, at_end[0]},   32'd0);
        check("rst_underrun", {31'd0, underrun[0]}, 32'd0);

        // Looping instance: 10 forward ticks, then 10 reverse ticks from a restart.
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                play = 1'b1; forward = 1'b1;
                do_reset();
                base = acc0.size();
            end else if (i == 10) begin
                for (int j = 0; j < 5; j++) check("fwd_addr", {9'd0, acc_at(0, base + j)},
                                                  {9'd0, exp_addr[j]});
                play = 1'b0; forward = 1'b0;
                do_reset();
                base = acc0.size();
                restart = 1'b1;
                cycles(1);
                restart = 1'b0;
                play    = 1'b1;
            end
            do_tick(7);
            check(vecs[i].fwd ? "fwd_valid" : "rev_valid", {31'd0, s_valid[0]}, 32'd1);
            check(vecs[i].fwd ? "fwd_sample" : "rev_sample", {16'd0, s_out[0]},
                  {16'd0, vecs[i].samp});
            check("no_underrun", {31'd0, underrun[0]}, 32'd0);
        end
        for (int j = 0; j < 5; j++) check("rev_addr", {9'd0, acc_at(0, base + j)},
                                          {9'd0, exp_addr[5 + j]});

        // Stop-at-end instance: 4 samples, at_end with the last, then idle until restart.
        forward = 1'b1; play = 1'b1;
        do_reset();
        v0 = end_cnt[1];
        for (int k = 0; k < 4; k++) begin
            do_tick(7);
            check("stop_valid",  {31'd0, s_valid[1]}, 32'd1);
            check("stop_sample", {16'd0, s_out[1]},   k);
            check("stop_at_end", {31'd0, at_end[1]},  (k == 3) ? 32'd1 : 32'd0);
        end
        n0 = read_cyc[1];
        cycles(20);
        check("stop_no_read", read_cyc[1] - n0, 0);
        check("stop_end_once", end_cnt[1] - v0, 1);
        do_tick(0);
        check("stop_tick_underrun", {31'd0, underrun[1]}, 32'd0);
        check("stop_tick_valid",    {31'd0, s_valid[1]},  32'd0);
        n0 = acc1.size();
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        cycles(10);
        check("stop_refetch_cnt",  acc1.size() - n0, 1);
        check("stop_refetch_addr", {9'd0, acc_at(1, acc1.size() - 1)}, 32'd0);
        do_tick(0);
        check("stop_resume", {15'd0, s_valid[1], s_out[1]}, 32'h1_0000);

        // Waitrequest stall: request held 6 cycles, ticks during it underrun.
        wr[0] = 1'b1;
        do_reset();
        wait_read(0);
        for (int j = 0; j < 6; j++) begin
            check("stall_read", {31'd0, f_read[0]}, 32'd1);
            check("stall_addr", {9'd0, f_addr[0]},  32'd0);
            if (j == 2 || j == 4) begin
                check("stall_underrun", {31'd0, underrun[0]}, 32'd1);
                check("stall_sample",   {15'd0, s_valid[0], s_out[0]}, 32'd0);
                sample_tick = 1'b0;
            end else if (j == 3) begin
                check("stall_underrun_pulse", {31'd0, underrun[0]}, 32'd0);
            end
            if (j == 1 || j == 3) sample_tick = 1'b1;
            if (j == 5) wr[0] = 1'b0;
            cycles(1);
        end
        check("stall_read_drop", {31'd0, f_read[0]}, 32'd0);
        cycles(8);
        do_tick(0);
        check("stall_first", {15'd0, s_valid[0], s_out[0]}, 32'h1_0000);

        // Pause after 3 samples, resume, then asynchronous reset while a request stalls.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_tick(7);
            check("pause_pre", {16'd0, s_out[0]}, k);
        end
        play = 1'b0;
        cycles(1);
        v0 = valid_cnt[0];
        u0 = under_cnt[0];
        for (int k = 0; k < 20; k++) do_tick(1);
        cycles(1);
        check("pause_valid",    valid_cnt[0] - v0, 0);
        check("pause_underrun", under_cnt[0] - u0, 0);
        wr[0] = 1'b1;
        play  = 1'b1;
        do_tick(2);
        check("pause_resume", {15'd0, s_valid[0], s_out[0]}, 32'h1_0003);
        check("midreq_read", {31'd0, f_read[0]}, 32'd1);
        check("midreq_addr", {9'd0, f_addr[0]},  32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("async_read",   {31'd0, f_read[0]}, 32'd0);
        check("async_addr",   {9'd0, f_addr[0]},  32'd0);
        check("async_sample", {15'd0, s_valid[0], s_out[0]}, 32'd0);
        wr[0] = 1'b0;
        cycles(1);

        // Restart during WAIT_DATA drops the word; restart beats a same-cycle tick.
        do_reset();
        do_tick(7);
        do_tick(7);
        check("wd_req_addr", {8'd0, f_read[0], f_addr[0]}, {8'd0, 1'b1, 23'd1});
        n0 = acc0.size();
        cycles(1);
        v0 = valid_cnt[0];
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        cycles(10);
        check("wd_no_valid",   valid_cnt[0] - v0, 0);
        check("wd_fetch_cnt",  acc0.size() - n0, 2);
        check("wd_fetch_addr", {9'd0, acc_at(0, acc0.size() - 1)}, 32'd0);
        do_tick(0);
        check("wd_sample", {15'd0, s_valid[0], s_out[0]}, 32'h1_0000);
        cycles(7);
        sample_tick = 1'b1;
        restart     = 1'b1;
        cycles(1);
        sample_tick = 1'b0;
        restart     = 1'b0;
        check("restart_beats_tick", {31'd0, s_valid[0]}, 32'd0);
        cycles(10);
        do_tick(0);
        check("restart_refetch", {15'd0, s_valid[0], s_out[0]}, 32'h1_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_addr_gen.md
Name: audio_addr_gen

Overview:
- Parametrised flash-to-audio sample sequencer for the iPod playback path.
- Fetches DATA_W-bit words from flash over an Avalon-style read port and unpacks them into SAMPLE_W-bit samples, one per sample_tick.
- Walks the address range forward or in reverse, with loop-or-stop at the range ends, pause, restart and underrun flagging.
- Sits between the flash controller and the audio codec/volume-indicator logic.

Parameters:
ADDR_W, 23, flash word-address width
DATA_W, 32, flash read-data width
SAMPLE_W, 16, audio sample width; DATA_W/SAMPLE_W = SPW must be a power of two >= 1
START_ADDR, 0, first word address of the clip
END_ADDR, 23'h7FFFF, last word address of the clip (END_ADDR >= START_ADDR)
LOOP, 1, 1 = wrap at range end; 0 = stop at range end

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset_n  in  1  asynchronous, active-low reset
sample_tick  in  1  one-cycle pulse at the audio sample rate, synchronous to clk
play  in  1  level; 1 = run, 0 = pause
forward  in  1  level; 1 = ascending addresses, 0 = descending
restart  in  1  one-cycle pulse; rewind to the range start for the current direction
flash_read  out  1  read request
flash_addr  out  ADDR_W  word address for the read request
flash_waitrequest  in  1  slave stall signal
flash_readdatavalid  in  1  read data valid
flash_readdata  in  DATA_W  read data
sample_out  out  SAMPLE_W  current sample; held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
at_end  out  1  one-cycle pulse when a non-loop clip finishes
underrun  out  1  one-cycle pulse when a tick arrives with no buffered sample

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; addr=START_ADDR; stopped=0; restart_pend=0.
  - Outputs: flash_read=0, flash_addr=START_ADDR, sample_out=0, sample_valid=0, at_end=0, underrun=0.
- FSM states: IDLE, REQ, WAIT_DATA, READY.
- IDLE:
  - If play=1 and stopped=0, go to REQ next cycle.
- REQ:
  - flash_read=1 and flash_addr=addr, both registered.
  - Hold both stable while flash_waitrequest=1.
  - On the first cycle with flash_waitrequest=0, drop flash_read the next cycle and go to WAIT_DATA.
  - Exactly one outstanding read at a time.
- WAIT_DATA:
  - On flash_readdatavalid=1, latch flash_readdata into buf.
  - Latch dir=forward.
  - Set idx=0 if dir=1, else idx=SPW-1.
  - Go to READY.
- READY, on sample_tick=1 with play=1:
  - Next cycle: sample_out=buf[idx*SAMPLE_W +: SAMPLE_W] and sample_valid=1.
  - If the word is not exhausted, step idx by +1 when dir=1, or -1 when dir=0.
  - The word is exhausted at idx=SPW-1 when dir=1, or idx=0 when dir=0. When exhausted, advance addr, then go to REQ.
- Pause: play=0 in READY, or a tick that arrives with play=0, leaves buf, idx and addr unchanged with no output. play=0 in REQ/WAIT_DATA lets the transaction complete, then the FSM waits in READY.
- Address advance, dir=1:
  - addr==END_ADDR and LOOP=1: addr becomes START_ADDR.
  - addr==END_ADDR and LOOP=0: at_end pulses, stopped=1, addr=START_ADDR, go to IDLE.
  - Otherwise addr+1.
- Address advance, dir=0: mirror of dir=1, with START_ADDR as the boundary and END_ADDR as the wrap target.
- Direction change: takes effect at the next word fetch only. The current word finishes in its latched order.
- Underrun: sample_tick=1 and play=1 while state is IDLE (with stopped=0), REQ or WAIT_DATA gives underrun=1 for one cycle. sample_out is held, and the tick is not queued.
- restart in IDLE or READY:
  - Next cycle: addr=(forward ? START_ADDR : END_ADDR), stopped=0, state=IDLE.
  - buf contents are discarded.
- restart in REQ or WAIT_DATA:
  - Set restart_pend; the bus transaction completes normally.
  - The returned data is discarded, then the restart is applied as in IDLE/READY.
- Simultaneous events:
  - restart with sample_tick in the same cycle: restart wins, with no sample_valid.
  - at_end with sample_tick in the same cycle: the final sample is still emitted.
- SPW=1: every tick fetches a new word.
- Throughput requirement: the read-latency budget is one tick period minus 2 cycles.

Test Plan:
- Forward, overrides END_ADDR=3, LOOP=1; words 0..3 = 32'h0001_0000 + 32'h0002_0002*n; play=1, 10 ticks -> samples 0000,0001,0002,0003,...; flash_addr sequence 0,1,2,3,0.
- Reverse, forward=0, same image -> first fetch at addr 3; samples 0007,0006,0005,0004,...; wrap 0 -> 3.
- LOOP=0, forward, END_ADDR=1 -> 4 samples, then at_end pulses once; flash_read stays 0 while play=1; restart -> fetch at addr 0 resumes.
- flash_waitrequest held high 5 cycles -> flash_read and flash_addr stable for 6 cycles; ticks during the stall -> one underrun pulse each, sample_out unchanged.
- play=0 after 3 samples for 20 ticks -> no sample_valid, no underrun; play=1 -> next sample 0003.
- restart asserted during WAIT_DATA -> data discarded, no sample_valid; next fetch at START_ADDR. reset_n low mid-REQ -> flash_read=0 immediately, all outputs at reset values.
